// File: rtl/ram_sp_clr.sv
// ----------------------------------------------------------------------------
// ram_sp_clr
// Single-port synchronous RAM with byte-lane writes, a registered read with a
// valid flag, and a hardware clear engine that sweeps the whole array to zero
// after reset or on request.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset (starts a clear sweep)
//   cs       chip select; no access when low
//   we       write enable (qualified by cs)
//   oe       read enable (qualified by cs with we low)
//   be       byte-lane write enables, bit i covers data_in[8i+7:8i]
//   address  word address
//   data_in  write data
//   clr      one-cycle request to zero the whole array
//   data_out registered read data
//   rd_valid data_out holds fresh read data this cycle
//   busy     clear sweep in progress; accesses refused
//   err      one-cycle pulse: access attempted while busy
//
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ram_sp_clr #(
  parameter  int DATA_WIDTH = 8,
  parameter  int ADDR_WIDTH = 7,
  localparam int NB         = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  input  logic [NB-1:0]         be,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  // Last address of the sweep; the counter wraps to zero right after it.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [0:0]            state;
  logic [0:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] counter;

  logic                  access;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  refused;

  // Decoded access requests; only honoured in READY.
  assign access  = cs & (we | oe);
  assign wr_ok   = (state == READY) & cs & we;
  assign rd_ok   = (state == READY) & cs & ~we & oe;
  assign refused = (state == CLEAR) & access;

  // --------------------------------------------------------------------------
  // State register and sweep counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      counter <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        counter <= counter + 1'b1;
      end else if (clr) begin
        counter <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. clr during the sweep is ignored so the sweep is never
  // restarted or extended.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR: begin
        if (counter == LAST_ADDR) begin
          state_nxt = READY;
        end
      end
      READY: begin
        if (clr) begin
          state_nxt = CLEAR;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: busy follows the state directly so it drops on the same
  // edge that finishes the sweep.
  // --------------------------------------------------------------------------
  always_comb begin
    busy = 1'b1;
    case (state)
      CLEAR:   busy = 1'b1;
      READY:   busy = 1'b0;
      default: busy = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Memory array. Not reset; the sweep zeroes it one word per cycle. A write
  // coinciding with a clr request is still performed (it is swept away later).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[counter] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[address][8*i +: 8] <= data_in[8*i +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered read port and error pulse. data_out holds its last value when
  // no read is performed.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      err      <= refused;
      if (rd_ok) begin
        data_out <= mem[address];
      end
    end
  end

endmodule

`default_nettype wire
